ahb_lite_req_bridge: RTL and testbench
======================================

AHB_LITE_REQ_BRIDGE -- requirements
Module: ahb_lite_req_bridge

Interface
REQ-001 SHALL have parameter AHB_ADDR_WIDTH, default 32, meaning the haddr and client address width.
REQ-002 SHALL have parameter AHB_DATA_WIDTH, default 32, meaning the hwdata, hrdata and client data width; legal values are 32 and 64.
REQ-003 SHALL have one clock and one reset; reset is synchronous and active-low.
REQ-004 Ports (name, direction, width, meaning):
- hclk, input, 1, sole clock; all state on its rising edge.
- hreset_n, input, 1, synchronous active-low reset.
- haddr_i, input, AHB_ADDR_WIDTH, address-phase address.
- hwdata_i, input, AHB_DATA_WIDTH, data-phase write data.
- hsel_i, input, 1, responder select.
- hwrite_i, input, 1, 1 = write.
- hsize_i, input, 3, transfer size.
- htrans_i, input, 2, transfer type.
- hready_i, input, 1, bus-level ready.
- hreadyout_o, output, 1, responder ready.
- hresp_o, output, 1, 1 = ERROR.
- hrdata_o, output, AHB_DATA_WIDTH, read data.
- dv_o, output, 1, client request valid.
- write_o, output, 1, client write.
- addr_o, output, AHB_ADDR_WIDTH, client address.
- wdata_o, output, AHB_DATA_WIDTH, client write data.
- size_o, output, 3, client size.
- hold_i, input, 1, client stall.
- rdata_i, input, AHB_DATA_WIDTH, client read data.
- error_i, input, 1, client error.

Function
REQ-005 SHALL accept an address phase when hsel_i && hready_i && htrans_i[1] is true at a rising edge; it SHALL capture haddr_i, hwrite_i and hsize_i.
REQ-006 SHALL ignore IDLE (00) and BUSY (01) transfers, or any cycle with hsel_i=0; the response is hreadyout_o=1, hresp_o=0, and dv_o stays low.
REQ-007 SHALL implement the states IDLE, DATA, ERR1 and ERR2 with these transitions:
- IDLE->DATA on an accepted legal transfer.
- IDLE->ERR1 on an accepted illegal transfer.
- DATA->ERR1 when hold_i=0 && error_i=1.
- DATA->DATA on hold_i=1, or on hold_i=0 with a new legal accept.
- DATA->IDLE on hold_i=0 with no accept.
- ERR1->ERR2 unconditionally.
- ERR2->DATA/ERR1/IDLE per any accept in that cycle.
REQ-008 SHALL treat a transfer as illegal when either condition holds; an illegal transfer SHALL never assert dv_o:
- hsize_i > log2(AHB_DATA_WIDTH/8);
- haddr_i is misaligned to hsize_i.
REQ-009 In DATA, SHALL drive client outputs as follows:
- dv_o=1;
- addr_o, write_o, size_o = the captured values;
- wdata_o = hwdata_i, combinationally.
REQ-010 In DATA, SHALL drive hreadyout_o = !hold_i; the captured address, write and size SHALL be held stable while hold_i=1.
REQ-011 On a read completing (DATA, hold_i=0, error_i=0), SHALL drive hrdata_o = rdata_i combinationally in that cycle; otherwise hrdata_o SHALL be 0.
REQ-012 Zero-wait latency: accept at edge N; client request visible in cycle N+1; completion in cycle N+1 if hold_i=0.
REQ-013 SHALL support back-to-back pipelining: an accept in the completing DATA cycle re-enters DATA with no idle cycle.
REQ-014 SHALL produce a two-cycle error response and SHALL hold dv_o=0 in both ERR states:
- ERR1: hresp_o=1, hreadyout_o=0.
- ERR2: hresp_o=1, hreadyout_o=1.
REQ-015 When error_i=1 arrives with hold_i=1, SHALL ignore it; error_i is sampled only when hold_i=0.
REQ-016 SHALL never accept a new address phase while hreadyout_o=0; this holds in DATA with hold and in ERR1.
REQ-017 SHALL drive hresp_o=0 in IDLE and DATA.

Reset
REQ-018 hreset_n=0 at a rising edge SHALL force the following, including mid-transfer and mid-error:
- state=IDLE;
- captured registers=0;
- dv_o=0, hresp_o=0, hreadyout_o=1;
- hrdata_o, addr_o, wdata_o, size_o, write_o = 0.
REQ-019 While hreset_n=0, SHALL accept no transfer and SHALL drive outputs per REQ-018.

Verification
REQ-020 Write case:
- Stimulus: NONSEQ write, haddr=0x10, hsize=2, hwdata=0xDEADBEEF next cycle, hold_i=0.
- Required response: one dv_o pulse, addr_o=0x10, wdata_o=0xDEADBEEF, hreadyout_o=1, hresp_o=0.
REQ-021 Read with wait states:
- Stimulus: read at 0x24, hold_i=1 for 3 cycles, then rdata_i=0x12345678.
- Required response: hreadyout_o=0 for 3 cycles; then hreadyout_o=1, hrdata_o=0x12345678; addr_o stable throughout.
REQ-022 Client error:
- Stimulus: read, hold_i=0, error_i=1.
- Required response: ERR1 cycle (hresp=1, hreadyout=0), then ERR2 (hresp=1, hreadyout=1), then IDLE.
REQ-023 Illegal transfers:
- Stimulus: hsize=2 at haddr=0x02, or hsize=3 with AHB_DATA_WIDTH=32.
- Required response: no dv_o; two-cycle error response.
REQ-024 Back-to-back:
- Stimulus: writes to 0x0, 0x4 and 0x8 on consecutive cycles, hold_i=0.
- Required response: dv_o high 3 consecutive cycles with addresses 0x0, 0x4, 0x8; hreadyout_o never low.
REQ-025 Reset mid-transfer:
- Stimulus: hreset_n=0 during DATA with hold_i=1.
- Required response: next cycle dv_o=0, hreadyout_o=1, hresp_o=0; a transfer after release completes normally.

Source files
------------

// File: rtl/ahb_lite_req_bridge.sv
// AHB-Lite responder that turns each accepted address phase into one client request,
// with hold-driven wait states and a two-cycle ERROR response for illegal or failed transfers.
module ahb_lite_req_bridge #(
  parameter int unsigned AHB_ADDR_WIDTH = 32,
  parameter int unsigned AHB_DATA_WIDTH = 32
) (
  input  logic                      hclk,
  input  logic                      hreset_n,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr_i,
  input  logic [AHB_DATA_WIDTH-1:0] hwdata_i,
  input  logic                      hsel_i,
  input  logic                      hwrite_i,
  input  logic [2:0]                hsize_i,
  input  logic [1:0]                htrans_i,
  input  logic                      hready_i,
  output logic                      hreadyout_o,
  output logic                      hresp_o,
  output logic [AHB_DATA_WIDTH-1:0] hrdata_o,
  output logic                      dv_o,
  output logic                      write_o,
  output logic [AHB_ADDR_WIDTH-1:0] addr_o,
  output logic [AHB_DATA_WIDTH-1:0] wdata_o,
  output logic [2:0]                size_o,
  input  logic                      hold_i,
  input  logic [AHB_DATA_WIDTH-1:0] rdata_i,
  input  logic                      error_i
);

  localparam int unsigned MAX_SIZE = (AHB_DATA_WIDTH == 64) ? 3 : 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [AHB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      write_q, write_d;
  logic [2:0]                size_q, size_d;

  logic [2:0] align_mask;
  logic       legal;
  logic       accept;
  logic       unused_htrans;

  // NONSEQ and SEQ are treated alike; only htrans[1] matters
  assign unused_htrans = htrans_i[0];

  // Transfer legality: size within the data bus and address aligned to that size
  always_comb begin
    case (hsize_i)
      3'd0:    align_mask = 3'b000;
      3'd1:    align_mask = 3'b001;
      3'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
    legal = (hsize_i <= 3'(MAX_SIZE)) && ((haddr_i[2:0] & align_mask) == 3'b000);
  end

  // Gating with our own hreadyout blocks accepts during hold and ERR1
  assign accept = hreset_n && hsel_i && hready_i && htrans_i[1] && hreadyout_o;

  // Response and client outputs, all decoded from the registered state
  always_comb begin
    hreadyout_o = 1'b1;
    hresp_o     = 1'b0;
    hrdata_o    = '0;
    dv_o        = 1'b0;
    write_o     = 1'b0;
    addr_o      = '0;
    wdata_o     = '0;
    size_o      = 3'd0;
    if (hreset_n) begin
      case (state_q)
        ST_DATA: begin
          dv_o        = 1'b1;
          write_o     = write_q;
          addr_o      = addr_q;
          wdata_o     = hwdata_i;
          size_o      = size_q;
          hreadyout_o = !hold_i;
          if (!hold_i && !error_i && !write_q) hrdata_o = rdata_i;
        end
        ST_ERR1: begin
          hresp_o     = 1'b1;
          hreadyout_o = 1'b0;
        end
        ST_ERR2: hresp_o = 1'b1;
        default: ;
      endcase
    end
  end

  // Next state and capture of the address phase
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    if (accept) begin
      addr_d  = haddr_i;
      write_d = hwrite_i;
      size_d  = hsize_i;
    end
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (accept) state_d = legal ? ST_DATA : ST_ERR1;
        else        state_d = ST_IDLE;
      end
      ST_DATA: begin
        if (!hold_i) begin
          if (error_i)     state_d = ST_ERR1;
          else if (accept) state_d = legal ? ST_DATA : ST_ERR1;
          else             state_d = ST_IDLE;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end

endmodule

// File: tb/tb_ahb_lite_req_bridge.sv
// Bench for ahb_lite_req_bridge: directed bus scenarios plus a randomized run
// against a transfer-level reference model.
module tb_ahb_lite_req_bridge;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned OW = 7 + AW + 2 * DW;

  logic          hclk = 1'b0;
  logic          hreset_n;
  logic [AW-1:0] haddr_i;
  logic [DW-1:0] hwdata_i;
  logic          hsel_i;
  logic          hwrite_i;
  logic [2:0]    hsize_i;
  logic [1:0]    htrans_i;
  logic          hready_i;
  logic          hreadyout_o;
  logic          hresp_o;
  logic [DW-1:0] hrdata_o;
  logic          dv_o;
  logic          write_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] wdata_o;
  logic [2:0]    size_o;
  logic          hold_i;
  logic [DW-1:0] rdata_i;
  logic          error_i;

  int total = 0;
  int bad   = 0;

  ahb_lite_req_bridge #(
    .AHB_ADDR_WIDTH(AW),
    .AHB_DATA_WIDTH(DW)
  ) dut (
    .hclk       (hclk),
    .hreset_n   (hreset_n),
    .haddr_i    (haddr_i),
    .hwdata_i   (hwdata_i),
    .hsel_i     (hsel_i),
    .hwrite_i   (hwrite_i),
    .hsize_i    (hsize_i),
    .htrans_i   (htrans_i),
    .hready_i   (hready_i),
    .hreadyout_o(hreadyout_o),
    .hresp_o    (hresp_o),
    .hrdata_o   (hrdata_o),
    .dv_o       (dv_o),
    .write_o    (write_o),
    .addr_o     (addr_o),
    .wdata_o    (wdata_o),
    .size_o     (size_o),
    .hold_i     (hold_i),
    .rdata_i    (rdata_i),
    .error_i    (error_i)
  );

  always #5 hclk = ~hclk;

  // Output tuple: {dv, hreadyout, hresp, write, size, addr, wdata, hrdata}
  function automatic logic [OW-1:0] obs();
    return {dv_o, hreadyout_o, hresp_o, write_o, size_o, addr_o, wdata_o, hrdata_o};
  endfunction

  function automatic logic [OW-1:0] mk(input logic dv, input logic rdy, input logic resp,
                                       input logic wr, input logic [2:0] sz,
                                       input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                       input logic [DW-1:0] rd);
    return {dv, rdy, resp, wr, sz, a, wd, rd};
  endfunction

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic bus_idle();
    hsel_i = 1'b0; htrans_i = 2'b00; hready_i = 1'b1; hwrite_i = 1'b0;
    hsize_i = 3'd0; haddr_i = '0; hwdata_i = '0;
    hold_i = 1'b0; error_i = 1'b0; rdata_i = '0;
  endtask

  task automatic addr_phase(input logic [AW-1:0] a, input logic wr, input logic [2:0] sz);
    hsel_i = 1'b1; htrans_i = 2'b10; hready_i = 1'b1;
    haddr_i = a; hwrite_i = wr; hsize_i = sz;
  endtask

  task automatic no_addr();
    hsel_i = 1'b0; htrans_i = 2'b00;
  endtask

  task automatic test_reset();
    logic [OW-1:0] e;
    bus_idle();
    hreset_n = 1'b0;
    addr_phase(32'h10, 1'b1, 3'd2);
    tick(); tick();
    @(negedge hclk);
    e = mk(0, 1, 0, 0, 3'd0, '0, '0, '0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL reset_outputs: got %h want %h", obs(), e); end
    tick();
    hreset_n = 1'b1;
    no_addr();
    @(negedge hclk);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL reset_no_accept: got %h want %h", obs(), e); end
    tick();
  endtask

  task automatic test_write();
    logic [OW-1:0] e;
    addr_phase(32'h10, 1'b1, 3'd2);
    @(negedge hclk);
    e = mk(0, 1, 0, 0, 3'd0, '0, '0, '0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL write_addr: got %h want %h", obs(), e); end
    tick();
    no_addr();
    hwdata_i = 32'hDEADBEEF;
    @(negedge hclk);
    e = mk(1, 1, 0, 1, 3'd2, 32'h10, 32'hDEADBEEF, '0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL write_data: got %h want %h", obs(), e); end
    tick();
    hwdata_i = '0;
    @(negedge hclk);
    e = mk(0, 1, 0, 0, 3'd0, '0, '0, '0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL write_done: got %h want %h", obs(), e); end
  endtask

  task automatic test_read_wait();
    logic [OW-1:0] e;
    addr_phase(32'h24, 1'b0, 3'd2);
    tick();
    // Address phases and client errors during hold must both be ignored
    addr_phase(32'h80, 1'b1, 3'd2);
    hold_i = 1'b1; error_i = 1'b1; rdata_i = 32'hAAAA5555;
    for (int k = 0; k < 3; k++) begin
      @(negedge hclk);
      e = mk(1, 0, 0, 0, 3'd2, 32'h24, '0, '0);
      total++;
      if (obs() !== e) begin bad++; $display("FAIL read_wait%0d: got %h want %h", k, obs(), e); end
      tick();
    end
    no_addr();
    hold_i = 1'b0; error_i = 1'b0; rdata_i = 32'h12345678;
    @(negedge hclk);
    e = mk(1, 1, 0, 0, 3'd2, 32'h24, '0, 32'h12345678);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL read_done: got %h want %h", obs(), e); end
    tick();
    rdata_i = '0;
    @(negedge hclk);
    e = mk(0, 1, 0, 0, 3'd0, '0, '0, '0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL read_idle: got %h want %h", obs(), e); end
  endtask

  task automatic test_client_error();
    logic [OW-1:0] e;
    addr_phase(32'h30, 1'b0, 3'd2);
    tick();
    no_addr();
    hold_i = 1'b0; error_i = 1'b1; rdata_i = 32'h0000FFFF;
    @(negedge hclk);
    e = mk(1, 1, 0, 0, 3'd2, 32'h30, '0, '0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL cerr_data: got %h want %h", obs(), e); end
    tick();
    error_i = 1'b0; rdata_i = '0;
    addr_phase(32'h90, 1'b1, 3'd2);
    @(negedge hclk);
    e = mk(0, 0, 1, 0, 3'd0, '0, '0, '0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL cerr_err1: got %h want %h", obs(), e); end
    tick();
    no_addr();
    @(negedge hclk);
    e = mk(0, 1, 1, 0, 3'd0, '0, '0, '0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL cerr_err2: got %h want %h", obs(), e); end
    tick();
    @(negedge hclk);
    e = mk(0, 1, 0, 0, 3'd0, '0, '0, '0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL cerr_idle: got %h want %h", obs(), e); end
  endtask

  task automatic test_illegal();
    logic [OW-1:0] e;
    logic [AW-1:0] a;
    logic [2:0]    sz;
    for (int c = 0; c < 2; c++) begin
      a  = (c == 0) ? 32'h02 : 32'h00;
      sz = (c == 0) ? 3'd2 : 3'd3;
      addr_phase(a, 1'b1, sz);
      tick();
      no_addr();
      @(negedge hclk);
      e = mk(0, 0, 1, 0, 3'd0, '0, '0, '0);
      total++;
      if (obs() !== e) begin bad++; $display("FAIL illegal%0d_err1: got %h want %h", c, obs(), e); end
      tick();
      @(negedge hclk);
      e = mk(0, 1, 1, 0, 3'd0, '0, '0, '0);
      total++;
      if (obs() !== e) begin bad++; $display("FAIL illegal%0d_err2: got %h want %h", c, obs(), e); end
      tick();
      @(negedge hclk);
      e = mk(0, 1, 0, 0, 3'd0, '0, '0, '0);
      total++;
      if (obs() !== e) begin bad++; $display("FAIL illegal%0d_idle: got %h want %h", c, obs(), e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] e;
    addr_phase(32'h0, 1'b1, 3'd2);
    tick();
    for (int k = 0; k < 3; k++) begin
      if (k < 2) addr_phase(AW'(4 * (k + 1)), 1'b1, 3'd2);
      else       no_addr();
      hwdata_i = DW'(32'h1000 + k);
      @(negedge hclk);
      e = mk(1, 1, 0, 1, 3'd2, AW'(4 * k), DW'(32'h1000 + k), '0);
      total++;
      if (obs() !== e) begin bad++; $display("FAIL b2b%0d: got %h want %h", k, obs(), e); end
      tick();
    end
    hwdata_i = '0;
    @(negedge hclk);
    e = mk(0, 1, 0, 0, 3'd0, '0, '0, '0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL b2b_idle: got %h want %h", obs(), e); end
  endtask

  task automatic test_reset_mid();
    logic [OW-1:0] e;
    addr_phase(32'h50, 1'b0, 3'd2);
    tick();
    no_addr();
    hold_i = 1'b1;
    @(negedge hclk);
    e = mk(1, 0, 0, 0, 3'd2, 32'h50, '0, '0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL rstmid_hold: got %h want %h", obs(), e); end
    tick();
    hreset_n = 1'b0;
    tick();
    hreset_n = 1'b1;
    @(negedge hclk);
    e = mk(0, 1, 0, 0, 3'd0, '0, '0, '0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL rstmid_after: got %h want %h", obs(), e); end
    hold_i = 1'b0;
    tick();
    addr_phase(32'h60, 1'b1, 3'd1);
    tick();
    no_addr();
    hwdata_i = 32'hCAFE0001;
    @(negedge hclk);
    e = mk(1, 1, 0, 1, 3'd1, 32'h60, 32'hCAFE0001, '0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL rstmid_xfer: got %h want %h", obs(), e); end
    tick();
    hwdata_i = '0;
  endtask

  // Transfer-level model: one outstanding transfer and a count of error cycles left
  task automatic test_random(input int n);
    logic [OW-1:0] e;
    bit            busy;
    logic [AW-1:0] c_addr;
    logic          c_write;
    logic [2:0]    c_size;
    int            err_left;
    bit            rdy, acc, ok;
    bus_idle();
    hreset_n = 1'b0;
    tick();
    hreset_n = 1'b1;
    busy = 0; err_left = 0; c_addr = '0; c_write = 1'b0; c_size = 3'd0;
    for (int i = 0; i < n; i++) begin
      hsel_i   = ($urandom_range(0, 3) != 0);
      htrans_i = 2'($urandom_range(0, 3));
      hready_i = ($urandom_range(0, 7) != 0);
      hwrite_i = 1'($urandom);
      hsize_i  = 3'($urandom_range(0, 3));
      haddr_i  = $urandom;
      if ($urandom_range(0, 3) != 0) haddr_i = haddr_i & ~((32'd1 << hsize_i) - 32'd1);
      hwdata_i = $urandom;
      rdata_i  = $urandom;
      hold_i   = ($urandom_range(0, 3) == 0);
      error_i  = ($urandom_range(0, 5) == 0);
      if (err_left == 2) begin
        rdy = 0; e = mk(0, 0, 1, 0, 3'd0, '0, '0, '0);
      end else if (err_left == 1) begin
        rdy = 1; e = mk(0, 1, 1, 0, 3'd0, '0, '0, '0);
      end else if (busy) begin
        rdy = !hold_i;
        e = mk(1, rdy, 0, c_write, c_size, c_addr, hwdata_i,
               (!hold_i && !error_i && !c_write) ? rdata_i : '0);
      end else begin
        rdy = 1; e = mk(0, 1, 0, 0, 3'd0, '0, '0, '0);
      end
      @(negedge hclk);
      total++;
      if (obs() !== e) begin bad++; $display("FAIL random_cyc%0d: got %h want %h", i, obs(), e); end
      acc = hsel_i && hready_i && htrans_i[1] && rdy;
      ok  = (hsize_i <= 3'd2) && ((haddr_i % (32'd1 << hsize_i)) == 0);
      if (err_left == 2) begin
        err_left = 1;
      end else if (busy && hold_i) begin
        busy = 1;
      end else if (busy && error_i) begin
        busy = 0; err_left = 2;
      end else begin
        busy = 0; err_left = 0;
        if (acc) begin
          if (ok) begin busy = 1; c_addr = haddr_i; c_write = hwrite_i; c_size = hsize_i; end
          else err_left = 2;
        end
      end
      tick();
    end
    bus_idle();
  endtask

  initial begin
    test_reset();
    test_write();
    tick();
    test_read_wait();
    tick();
    test_client_error();
    tick();
    test_illegal();
    tick();
    test_back_to_back();
    tick();
    test_reset_mid();
    test_random(3000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
